// File: rtl/key_event_decoder_pkg.sv
// Shared types and defaults for the per-key gesture decoder.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        LONG,
        WAIT2,
        PRESS2
    } state_t;

    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_LONG_MS   = 1000;
    localparam int DEF_DCLICK_MS = 300;
    localparam int DEF_REPEAT_MS = 200;
    localparam int DEF_MS_W      = 16;

    function automatic int ms_div(input int clk_freq);
        return clk_freq / 1000;
    endfunction

endpackage

// File: rtl/key_event_decoder_ms_tick_gen.sv
// 1 ms tick prescaler; clr restarts the millisecond so gesture timing aligns to state entry.
module ms_tick_gen
    import key_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV   = ms_div(CLK_FREQ);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == TERM);

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures into short / long / repeat / double-click pulses.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int CLK_FREQ  = DEF_CLK_FREQ,
    parameter int LONG_MS   = DEF_LONG_MS,
    parameter int DCLICK_MS = DEF_DCLICK_MS,
    parameter int REPEAT_MS = DEF_REPEAT_MS,
    parameter int MS_W      = DEF_MS_W
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_value,
    output logic short_press,
    output logic long_press,
    output logic repeat_press,
    output logic double_click,
    output logic busy
);

    localparam logic [MS_W-1:0] LONG_T   = MS_W'(LONG_MS);
    localparam logic [MS_W-1:0] DCLICK_T = MS_W'(DCLICK_MS);
    localparam logic [MS_W-1:0] REPEAT_T = MS_W'(REPEAT_MS);

    state_t          state;
    state_t          state_nx;
    logic [MS_W-1:0] ms_cnt;
    logic            key_value_d;
    logic            rel;
    logic            prs;
    logic            tick;
    logic            clr;
    logic            short_nx;
    logic            long_nx;
    logic            repeat_nx;
    logic            double_nx;

    assign rel  = key_value & ~key_value_d;
    assign prs  = key_flag & ~key_value;
    assign busy = (state != IDLE);

    ms_tick_gen #(
        .CLK_FREQ(CLK_FREQ)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick)
    );

    // Release / second press are tested before the timers so they win ties.
    always_comb begin
        state_nx  = state;
        clr       = 1'b0;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        repeat_nx = 1'b0;
        double_nx = 1'b0;
        case (state)
            IDLE: begin
                if (prs) state_nx = PRESS1;
            end
            PRESS1: begin
                if (rel) begin
                    state_nx = WAIT2;
                end else if (ms_cnt == LONG_T) begin
                    state_nx = LONG;
                    long_nx  = 1'b1;
                end
            end
            LONG: begin
                if (rel) begin
                    state_nx = IDLE;
                end else if (ms_cnt == REPEAT_T) begin
                    repeat_nx = 1'b1;
                    clr       = 1'b1;
                end
            end
            WAIT2: begin
                if (prs) begin
                    state_nx = PRESS2;
                end else if (ms_cnt == DCLICK_T) begin
                    state_nx = IDLE;
                    short_nx = 1'b1;
                end
            end
            PRESS2: begin
                if (rel) begin
                    state_nx  = IDLE;
                    double_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx != state) clr = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ms_cnt       <= '0;
            key_value_d  <= 1'b1;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_press <= 1'b0;
            double_click <= 1'b0;
        end else begin
            state        <= state_nx;
            key_value_d  <= key_value;
            short_press  <= short_nx;
            long_press   <= long_nx;
            repeat_press <= repeat_nx;
            double_click <= double_nx;
            if (clr) begin
                ms_cnt <= '0;
            end else if (tick && (ms_cnt != '1)) begin
                ms_cnt <= ms_cnt + MS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Gesture table plus hand-built boundary sequences; pulses are scored against a timed queue.
module tb_key_event_decoder;

    localparam int CLK_FREQ  = 10_000;
    localparam int LONG_MS   = 100;
    localparam int DCLICK_MS = 30;
    localparam int REPEAT_MS = 20;
    localparam int MS_W      = 16;
    localparam int MS        = CLK_FREQ / 1000;

    localparam int K_SHORT  = 0;
    localparam int K_LONG   = 1;
    localparam int K_REPEAT = 2;
    localparam int K_DOUBLE = 3;

    typedef struct {
        int kind;
        int cyc;
        int tol;
    } exp_t;

    typedef struct {
        int hold1;
        int gap;
        int hold2;
        int kind;
        int nrep;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic key_flag;
    logic key_value;
    logic short_press;
    logic long_press;
    logic repeat_press;
    logic double_click;
    logic busy;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[9];

    key_event_decoder #(
        .CLK_FREQ (CLK_FREQ),
        .LONG_MS  (LONG_MS),
        .DCLICK_MS(DCLICK_MS),
        .REPEAT_MS(REPEAT_MS),
        .MS_W     (MS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_flag    (key_flag),
        .key_value   (key_value),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_press(repeat_press),
        .double_click(double_click),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_SHORT:  return "short_press";
            K_LONG:   return "long_press";
            K_REPEAT: return "repeat_press";
            K_DOUBLE: return "double_click";
            default:  return "none";
        endcase
    endfunction

    // Every pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [3:0] p;
        int         k;
        int         d;
        exp_t       e;
        p = {short_press, long_press, repeat_press, double_click};
        if (p != 4'b0) begin
            k = short_press ? K_SHORT : long_press ? K_LONG : repeat_press ? K_REPEAT : K_DOUBLE;
            checks++;
            if (!$onehot(p)) begin
                errors++;
                $display("FAIL onehot: pulses %b at cyc %0d, want at most one", p, cyc);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected: got %s at cyc %0d, want no pulse", kname(k), cyc);
            end else begin
                e = sb.pop_front();
                d = cyc - e.cyc;
                if (d < 0) d = -d;
                if (e.kind != k || d > e.tol) begin
                    errors++;
                    $display("FAIL event: got %s at cyc %0d, want %s at cyc %0d +/-%0d",
                             kname(k), cyc, kname(e.kind), e.cyc, e.tol);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push(input int kind, input int at, input int tol);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        e.tol  = tol;
        sb.push_back(e);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press pulse lasts one clock; returns one negedge later.
    task automatic press();
        key_value = 1'b0;
        key_flag  = 1'b1;
        @(negedge clk);
        key_flag = 1'b0;
    endtask

    task automatic settle(input string name);
        int i;
        i = 0;
        while (busy && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check({name, "_idle"}, int'(busy), 0);
        wait_clk(10 * MS);
        check({name, "_drained"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int c0;
        int cr;
        int cr2;
        c0 = cyc;
        if (v.kind == K_LONG) begin
            push(K_LONG, c0 + 1 + LONG_MS * MS, 2);
            for (int k = 1; k <= v.nrep; k++)
                push(K_REPEAT, c0 + 1 + (LONG_MS + k * REPEAT_MS) * MS, 1 + k);
        end
        press();
        wait_clk(v.hold1 * MS - 1);
        key_value = 1'b1;
        cr = cyc;
        if (v.kind == K_SHORT) push(K_SHORT, cr + 1 + DCLICK_MS * MS, 1);
        if (v.kind == K_LONG) begin
            @(negedge clk);
            check($sformatf("vec%0d_long_rel_busy", idx), int'(busy), 0);
        end
        if (v.gap >= 0) begin
            wait_clk(v.gap * MS);
            press();
            wait_clk(v.hold2 * MS - 1);
            key_value = 1'b1;
            cr2 = cyc;
            push(K_DOUBLE, cr2 + 1, 0);
        end
        settle($sformatf("vec%0d", idx));
    endtask

    initial begin
        int c0;
        int cr;

        vecs[0] = '{40, -1, 0, K_SHORT, 0};
        vecs[1] = '{99, -1, 0, K_SHORT, 0};
        vecs[2] = '{5, -1, 0, K_SHORT, 0};
        vecs[3] = '{165, -1, 0, K_LONG, 3};
        vecs[4] = '{105, -1, 0, K_LONG, 0};
        vecs[5] = '{130, -1, 0, K_LONG, 1};
        vecs[6] = '{20, 15, 10, K_DOUBLE, 0};
        vecs[7] = '{20, 25, 150, K_DOUBLE, 0};
        vecs[8] = '{10, 5, 3, K_DOUBLE, 0};

        rst       = 1'b1;
        key_flag  = 1'b0;
        key_value = 1'b1;
        wait_clk(3);
        check("rst_short", int'(short_press), 0);
        check("rst_long", int'(long_press), 0);
        check("rst_repeat", int'(repeat_press), 0);
        check("rst_double", int'(double_click), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        wait_clk(5);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Second press lands in the very cycle the window expires: it must win.
        press();
        wait_clk(20 * MS - 1);
        key_value = 1'b1;
        cr = cyc;
        wait_clk(1 + DCLICK_MS * MS);
        press();
        check("win_edge_press2_busy", int'(busy), 1);
        wait_clk(10 * MS - 1);
        key_value = 1'b1;
        push(K_DOUBLE, cyc + 1, 0);
        settle("win_edge");

        // Second press one clock late: short fires, then a fresh gesture begins.
        press();
        wait_clk(20 * MS - 1);
        key_value = 1'b1;
        cr = cyc;
        wait_clk(1 + DCLICK_MS * MS);
        push(K_SHORT, cr + 2 + DCLICK_MS * MS, 0);
        @(negedge clk);
        press();
        check("win_late_new_busy", int'(busy), 1);
        wait_clk(10 * MS - 1);
        key_value = 1'b1;
        push(K_SHORT, cyc + 1 + DCLICK_MS * MS, 1);
        settle("win_late");

        // Release in the same cycle the long threshold is reached: release wins.
        c0 = cyc;
        press();
        wait_clk(LONG_MS * MS);
        key_value = 1'b1;
        cr = cyc;
        check("long_edge_hold", cr - c0, LONG_MS * MS + 1);
        push(K_SHORT, cr + 1 + DCLICK_MS * MS, 1);
        @(negedge clk);
        check("long_edge_wait2_busy", int'(busy), 1);
        settle("long_edge");

        // Reset while in LONG; stray key_flag pulses while held are ignored.
        c0 = cyc;
        push(K_LONG, c0 + 1 + LONG_MS * MS, 2);
        press();
        wait_clk(30 * MS);
        key_flag = 1'b1;
        @(negedge clk);
        key_flag = 1'b0;
        wait_clk((LONG_MS + 10) * MS - 30 * MS - 2);
        check("mid_long_busy", int'(busy), 1);
        check("mid_long_sb", sb.size(), 0);
        rst = 1'b1;
        wait_clk(2);
        check("midrst_short", int'(short_press), 0);
        check("midrst_long", int'(long_press), 0);
        check("midrst_repeat", int'(repeat_press), 0);
        check("midrst_double", int'(double_click), 0);
        check("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        wait_clk(5 * MS);
        key_value = 1'b1;
        wait_clk(60 * MS);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_sb", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
